// File: rtl/knn_distance_accumulator.sv
// knn_distance_accumulator: accumulates saturating squared Euclidean distance
// between an input sample and a training sample, one element per cycle.
module knn_distance_accumulator #(
    parameter int M            = 4,
    parameter int N            = 4,
    parameter int W            = 8,
    parameter int MAX_ELEMENTS = 16,
    parameter int TYPE_W       = 4,
    parameter int D_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_done,
    input  logic [W*MAX_ELEMENTS-1:0] input_data,
    input  logic [W*MAX_ELEMENTS-1:0] training_data,
    input  logic [TYPE_W-1:0]         training_data_type,
    output logic                      data_request,
    output logic                      done,
    output logic [D_W-1:0]            distance,
    output logic [TYPE_W-1:0]         distance_type,
    output logic                      busy,
    output logic                      overrun
);
    localparam int S     = M * N;
    localparam int CHUNK = (MAX_ELEMENTS < S) ? MAX_ELEMENTS : S;
    localparam int CW    = $clog2(S + 1);
    localparam int EW    = $clog2(CHUNK + 1);
    localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, EMIT = 2'd2;

    logic [1:0]                state;
    logic [W*MAX_ELEMENTS-1:0] in_r, tr_r;
    logic [TYPE_W-1:0]         ty_r;
    logic [CW-1:0]             consumed, rem;
    logic [EW-1:0]             e, k, kn;
    logic [D_W-1:0]            acc, acc_next;
    logic [W-1:0]              a, b, d;
    logic [2*W-1:0]            sq;
    logic [D_W:0]              sum;

    always_comb begin
        a        = in_r[e*W +: W];
        b        = tr_r[e*W +: W];
        d        = (a > b) ? a - b : b - a;
        sq       = {{W{1'b0}}, d} * {{W{1'b0}}, d};
        sum      = {1'b0, acc} + {{(D_W+1-2*W){1'b0}}, sq};
        acc_next = sum[D_W] ? '1 : sum[D_W-1:0];
        rem      = CW'(S) - consumed;
        kn       = (rem < CW'(CHUNK)) ? EW'(rem) : EW'(CHUNK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            in_r          <= '0;
            tr_r          <= '0;
            ty_r          <= '0;
            consumed      <= '0;
            e             <= '0;
            k             <= '0;
            acc           <= '0;
            data_request  <= 1'b0;
            done          <= 1'b0;
            distance      <= '0;
            distance_type <= '0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            data_request <= 1'b0;
            done         <= 1'b0;
            // busy covers the pulse cycle too, so it drops one edge after EMIT
            busy         <= (state != IDLE) | read_done;
            if (read_done && state != IDLE) overrun <= 1'b1;
            if (state == IDLE) begin
                if (read_done) begin
                    in_r  <= input_data;
                    tr_r  <= training_data;
                    k     <= kn;
                    e     <= '0;
                    state <= ACC;
                    if (consumed == '0) begin
                        ty_r <= training_data_type;
                        acc  <= '0;
                    end
                end
            end else if (state == ACC) begin
                acc      <= acc_next;
                e        <= e + 1'b1;
                consumed <= consumed + 1'b1;
                if (e == k - 1'b1) state <= EMIT;
            end else begin
                state <= IDLE;
                if (consumed < CW'(S)) begin
                    data_request <= 1'b1;
                end else begin
                    done          <= 1'b1;
                    distance      <= acc;
                    distance_type <= ty_r;
                    consumed      <= '0;
                end
            end
        end
    end
endmodule

// File: doc/knn_distance_accumulator.md
# knn_distance_accumulator

Distance stage of the KNN datapath, directly downstream of memory control. It consumes the chunks that memory control delivers: the `input_data`/`training_data` word vectors, `training_data_type` and the `read_done` pulse. It accumulates the squared Euclidean distance between one input sample and one training sample, one element per cycle. When a sample needs more chunks it pulses `data_request`; when the sample is complete it pulses `done`, with the distance and training type valid for the downstream k-nearest selector.

## Interface
- `M`, 4: sample rows.
- `N`, 4: sample columns; a sample holds M*N elements.
- `W`, 8: element width, unsigned.
- `MAX_ELEMENTS`, 16: maximum elements per chunk.
- `TYPE_W`, 4: class/type width.
- `D_W`, 32: distance accumulator width; must be ≥ 2W.
- `clk` in 1: clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `read_done` in 1: one-cycle pulse; the chunk on the data inputs is valid in that cycle.
- `input_data` in W*MAX_ELEMENTS: input-sample chunk; element j is at bits [W*(j+1)-1 : W*j].
- `training_data` in W*MAX_ELEMENTS: training-sample chunk, same packing.
- `training_data_type` in TYPE_W: type of the current training sample.
- `data_request` out 1: one-cycle pulse requesting the next chunk of the same sample.
- `done` out 1: one-cycle pulse marking the sample complete.
- `distance` out D_W: final distance; holds its value until the next `done`.
- `distance_type` out TYPE_W: training type belonging to `distance`.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; set when `read_done` arrives while busy.

## Operation
- `CHUNK` = min(MAX_ELEMENTS, M*N).
- `consumed` counts the elements of the current sample, range 0..M*N.
- Chunk length `k` = min(CHUNK, M*N − consumed).
- States:
  - **IDLE.** On `read_done`, register both data vectors and compute `k`. If `consumed == 0`, also register `training_data_type` and clear the accumulator. Go to ACC with element index 0.
  - **ACC.** Each cycle, for element index `e`:
    - d = |in[e] − tr[e]|, W bits.
    - acc ← acc + d*d, where d*d is 2W bits.
    - `e`++ and `consumed`++.
    - After element k−1, go to EMIT.
  - **EMIT.** One cycle.
    - If `consumed < M*N`: pulse `data_request`.
    - Else: pulse `done`, load `distance` ← acc and `distance_type` ← latched type, and clear `consumed` to 0.
    - Then go to IDLE.
- Arithmetic:
  - All operands are unsigned.
  - The accumulator saturates at 2^D_W − 1 and never wraps; once saturated it stays saturated until cleared.
- `data_request` and `done` are never high in the same cycle.
- Between them, exactly one pulse is produced per chunk.
- `read_done` while busy (ACC or EMIT):
  - The chunk is ignored; registered data, counters and accumulator are unaffected.
  - `overrun` ← 1, cleared only by `rst`.
- `read_done` in the same cycle as the EMIT-to-IDLE transition is also ignored and sets `overrun`. Memory control never issues this in normal flow.
- Reset values:
  - `data_request`, `done`, `busy`, `overrun` = 0.
  - `distance` = 0, `distance_type` = 0.
  - State = IDLE; `consumed`, acc and `e` = 0.
- Reset mid-operation (in ACC or EMIT) discards the partial sample. No pulse is emitted.

## Timing
- The `read_done` pulse is sampled at edge t.
- ACC processes element 0 at edge t+1 and element k−1 at edge t+k.
- `data_request`/`done` are high during the cycle after edge t+k+1, for exactly one cycle.
- `distance` is valid from the same edge as `done`.
- `busy` rises at edge t and falls at edge t+k+2.
- The earliest next accepted `read_done` is at edge t+k+2.
- Throughput: k+2 cycles per chunk.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- **Single chunk.** M=N=2, W=8, MAX_ELEMENTS=16. Stimulus: input {1,2,3,4}, training {4,2,3,1}, type 5. Required:
  - `done` in the cycle after edge t+5.
  - `distance` = 18, `distance_type` = 5.
  - `data_request` never asserted.
- **Multi-chunk.** M=N=3, MAX_ELEMENTS=4, all input elements 10, all training elements 7. Issue `read_done` after each pulse. Required:
  - `data_request` after chunks 1 and 2, which have k=4.
  - `done` after chunk 3, which has k=1, with `distance` = 81.
- **Back-to-back samples.** Two consecutive samples with types 2 and 9. Required:
  - The second `distance` excludes the first sample's accumulation.
  - `distance_type` reads 2, then 9.
- **Saturation.** D_W=16, W=8, M=N=2; input all 255, training all 0. Required: `distance` = 0xFFFF, since the true sum 260100 does not fit.
- **Overrun.** Pulse `read_done` again in the second ACC cycle. Required:
  - `overrun` = 1 and stays high.
  - The result equals that of the first chunk only.
- **Reset mid-ACC.** Assert `rst` in ACC, then send a fresh sample. Required:
  - No pulse during reset.
  - Outputs return to 0.
  - The fresh sample's distance is correct, with no residue from the aborted sample.
